// File: rtl/alu_arb_pkg.sv
// Shared constants for the ALU share arbiter: FSM state codes and default widths.
package alu_arb_pkg;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_EXEC = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   localparam int NREQ_DEF = 4;
   localparam int DW_DEF   = 4;
   localparam int OPW_DEF  = 3;
   localparam int RW_DEF   = 8;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request scanning upward from last+1, wrapping.
module rr_picker #(
   parameter int NREQ = 4,
   parameter int IW   = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   last,
   output logic [NREQ-1:0] grant,
   output logic [IW-1:0]   idx,
   output logic            any
);

   always_comb begin
      logic          found;
      logic [IW-1:0] j;
      grant = '0;
      idx   = '0;
      found = 1'b0;
      j     = '0;
      for (int unsigned off = 1; off <= NREQ; off++) begin
         j = IW'((32'(last) + off) % NREQ);
         if (!found && req[j]) begin
            found    = 1'b1;
            grant[j] = 1'b1;
            idx      = j;
         end
      end
   end

   assign any = |req;

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU among NREQ requesters with round-robin arbitration.
// Optional macro ALU_ARB_PRIO0_EN: requester 0 has absolute priority over the round-robin pool.
module alu_share_arbiter
   import alu_arb_pkg::*;
#(
   parameter int NREQ = NREQ_DEF,
   parameter int DW   = DW_DEF,
   parameter int OPW  = OPW_DEF,
   parameter int RW   = RW_DEF,
   parameter int IW   = $clog2(NREQ)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [NREQ*DW-1:0]  req_a,
   input  logic [NREQ*DW-1:0]  req_b,
   input  logic [NREQ*OPW-1:0] req_op,
   output logic [DW-1:0]     alu_a,
   output logic [DW-1:0]     alu_b,
   output logic [OPW-1:0]    alu_opcode,
   output logic              alu_enable,
   input  logic [RW-1:0]     alu_result,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [IW-1:0]     rsp_id,
   output logic [RW-1:0]     rsp_result,
   output logic              busy
);

   logic [1:0]      state;
   logic [IW-1:0]   last_grant;
   logic [NREQ-1:0] pick_req;
   logic [NREQ-1:0] pick_grant;
   logic [IW-1:0]   pick_idx;
   logic            pick_any;
   logic [NREQ-1:0] sel_grant;
   logic [IW-1:0]   sel_id;
   logic            sel_any;
   logic            xfer;
   logic [DW-1:0]   a_q;
   logic [DW-1:0]   b_q;
   logic [OPW-1:0]  op_q;
   logic [IW-1:0]   id_q;
   logic [IW-1:0]   rsp_id_q;
   logic [RW-1:0]   rsp_result_q;

   rr_picker #(
      .NREQ (NREQ),
      .IW   (IW)
   ) u_picker (
      .req   (pick_req),
      .last  (last_grant),
      .grant (pick_grant),
      .idx   (pick_idx),
      .any   (pick_any)
   );

`ifdef ALU_ARB_PRIO0_EN
   // Requester 0 is excluded from the rotating pool and overrides it when valid.
   assign pick_req = req_valid & ~NREQ'(1);

   always_comb begin
      sel_grant = pick_grant;
      sel_id    = pick_idx;
      sel_any   = pick_any;
      if (req_valid[0]) begin
         sel_grant = NREQ'(1);
         sel_id    = '0;
         sel_any   = 1'b1;
      end
   end
`else
   assign pick_req  = req_valid;
   assign sel_grant = pick_grant;
   assign sel_id    = pick_idx;
   assign sel_any   = pick_any;
`endif

   assign req_ready  = (state == S_IDLE) ? sel_grant : '0;
   assign xfer       = (state == S_IDLE) && sel_any;
   assign alu_enable = (state == S_EXEC);
   assign alu_a      = a_q;
   assign alu_b      = b_q;
   assign alu_opcode = op_q;
   assign rsp_valid  = (state == S_RESP);
   assign rsp_id     = rsp_id_q;
   assign rsp_result = rsp_result_q;
   assign busy       = (state != S_IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= S_IDLE;
         last_grant   <= IW'(NREQ - 1);
         a_q          <= '0;
         b_q          <= '0;
         op_q         <= '0;
         id_q         <= '0;
         rsp_id_q     <= '0;
         rsp_result_q <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (xfer) begin
                  a_q   <= req_a[int'(sel_id)*DW +: DW];
                  b_q   <= req_b[int'(sel_id)*DW +: DW];
                  op_q  <= req_op[int'(sel_id)*OPW +: OPW];
                  id_q  <= sel_id;
`ifdef ALU_ARB_PRIO0_EN
                  if (!req_valid[0]) last_grant <= sel_id;
`else
                  last_grant <= sel_id;
`endif
                  state <= S_EXEC;
               end
            end
            S_EXEC: begin
               rsp_result_q <= alu_result;
               rsp_id_q     <= id_q;
               state        <= S_RESP;
            end
            S_RESP: begin
               if (rsp_ready) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
